pipeline_perf_monitor: RTL and testbench
========================================

Name: pipeline_perf_monitor

Overview:
Hardware performance monitor attached to the pipelined CPU top. It consumes the per-cycle hazard, control and writeback signals and keeps cycle, stall, flush and retired-instruction counts, replacing counting logic currently done in simulation. After a programmable number of run cycles it raises a halt request, giving a deterministic end-of-run that both simulation and a debug read port can use.

Parameters:
CNT_W, 32, width of every counter and of rd_data_o
CYCLE_LIMIT, 10, run cycles before halt_o asserts; 0 = never halt

Ports:
clk_i  input  1  clock, all state updates on rising edge
start_i  input  1  synchronous active-low reset; low = reset
enable_i  input  1  level; start counting (IDLE->RUN)
clear_i  input  1  synchronous clear of counters and flags, return to IDLE
stall_i  input  1  hazard unit stall request (PC/IF-ID hold)
jump_i  input  1  decode-stage control Jump
branch_i  input  1  decode-stage control Branch
flush_i  input  1  IF/ID flush asserted this cycle
retire_i  input  1  valid instruction leaving WB this cycle
rd_addr_i  input  2  counter select: 0 cycle, 1 stall, 2 flush, 3 retired
rd_data_o  output  CNT_W  registered value of the selected counter
running_o  output  1  state == RUN
halt_o  output  1  run limit reached (sticky until clear/reset)
sat_o  output  1  sticky: some counter saturated

Behaviour:
- Reset (start_i=0 at clk edge): state IDLE; all four counters 0; rd_data_o 0; running_o 0; halt_o 0; sat_o 0. Reset overrides every other input.
- FSM: IDLE --enable_i--> RUN; RUN --cycle_cnt reaches CYCLE_LIMIT--> HALTED; HALTED stays until clear_i or reset. Any state --clear_i--> IDLE. enable_i deasserting in RUN does not stop counting.
- Counting only on edges where current state is RUN (registered state; the edge that leaves IDLE does not count):
  - cycle_cnt +1 every RUN cycle.
  - stall_cnt +1 when stall_i && !jump_i && !branch_i (control-hazard bubbles are not stalls).
  - flush_cnt +1 when flush_i.
  - retire_cnt +1 when retire_i.
  - Events in the same cycle increment their counters independently.
- Halt: on the RUN edge where cycle_cnt goes CYCLE_LIMIT-1 -> CYCLE_LIMIT, the state moves to HALTED and halt_o=1 from that edge on. Events sampled on that edge are still counted; nothing counts afterwards. CYCLE_LIMIT=0: never HALTED.
- Saturation: a counter at all-ones holds its value; an increment attempted at all-ones sets sat_o (sticky). There is no wrap-around.
- clear_i in the same cycle as any event or transition: clear wins. Counters go to 0, flags go to 0, state goes to IDLE.
- running_o is decoded from registered state, so it has zero extra latency.
- Read port: rd_data_o <= counter[rd_addr_i] each edge, giving 1-cycle latency. The value returned is the counter before that edge's increment. A read is coherent in all states.
- An X on event inputs while in IDLE or HALTED must not corrupt the counters.

Decomposition:
- Shared package perf_pkg:
  - State encoding IDLE=2'd0, RUN=2'd1, HALTED=2'd2.
  - Read-address constants PERF_CYC=0, PERF_STALL=1, PERF_FLUSH=2, PERF_RET=3.
- One natural sub-module: perf_sat_counter (CNT_W-wide saturating counter with inc, clr and sync active-low reset, plus a sat output). Instantiate it 4 times.
- FSM, halt compare and read mux stay in the top.

Test Plan:
1. Reset, enable_i=1 for one cycle, no events, CYCLE_LIMIT=10 -> running_o is high for exactly 10 edges; halt_o=1 after the 10th RUN edge; cycle_cnt reads 10; all other counters read 0.
2. In RUN, drive stall_i=1 for 3 cycles, with branch_i=1 during the 2nd of those cycles -> stall_cnt=2.
3. In RUN, drive flush_i and retire_i together for 4 cycles, then retire_i alone for 2 cycles -> flush_cnt=4, retire_cnt=6; rd_addr_i=3 shows 6 one edge after it is set.
4. CNT_W=4, CYCLE_LIMIT=0, run 20 cycles with retire_i=1 -> retire_cnt holds 15; sat_o=1; halt_o stays 0.
5. Assert clear_i together with stall_i in RUN (stall_cnt=5 beforehand) -> next edge: all counters 0, state IDLE, halt_o=0, sat_o=0.
6. Pull start_i low mid-run (cycle_cnt=7) and release -> all outputs 0; counting resumes only after enable_i.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared definitions for the pipeline performance monitor: FSM states and
// read-port counter selects.
package perf_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } perfState_e;

   localparam logic [1:0] PERF_CYC   = 2'd0;
   localparam logic [1:0] PERF_STALL = 2'd1;
   localparam logic [1:0] PERF_FLUSH = 2'd2;
   localparam logic [1:0] PERF_RET   = 2'd3;

   localparam int NUM_CNT = 4;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter: holds at all-ones and raises a sticky flag when
// an increment is attempted there.
module perf_sat_counter
   import perf_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             start_i,
   input  logic             inc_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] count_o,
   output logic             sat_o
);

   logic [CNT_W-1:0] r_count;
   logic             r_sat;

   always_ff @(posedge clk_i) begin
      if (!start_i) begin
         r_count <= '0;
         r_sat   <= 1'b0;
      end else if (clr_i) begin
         r_count <= '0;
         r_sat   <= 1'b0;
      end else if (inc_i) begin
         if (&r_count) begin
            r_sat <= 1'b1;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign count_o = r_count;
   assign sat_o   = r_sat;

endmodule

// File: rtl/pipeline_perf_monitor.sv
// Cycle/stall/flush/retire performance monitor with a run-length halt
// request and a registered counter read port.
module pipeline_perf_monitor
   import perf_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int CYCLE_LIMIT = 10
) (
   input  logic             clk_i,
   input  logic             start_i,
   input  logic             enable_i,
   input  logic             clear_i,
   input  logic             stall_i,
   input  logic             jump_i,
   input  logic             branch_i,
   input  logic             flush_i,
   input  logic             retire_i,
   input  logic [1:0]       rd_addr_i,
   output logic [CNT_W-1:0] rd_data_o,
   output logic             running_o,
   output logic             halt_o,
   output logic             sat_o
);

   localparam bit               HAS_LIMIT = (CYCLE_LIMIT != 0);
   localparam logic [CNT_W-1:0] LIMIT_M1  = CNT_W'(CYCLE_LIMIT - 1);

   perfState_e         r_state;
   perfState_e         w_nextState;
   logic               w_run;
   logic               w_limitHit;
   logic [NUM_CNT-1:0] w_inc;
   logic [NUM_CNT-1:0] w_sat;
   logic [CNT_W-1:0]   w_cnt [NUM_CNT];

   always_ff @(posedge clk_i) begin
      if (!start_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // The halting edge is the one on which the cycle counter steps onto the limit.
   assign w_limitHit = HAS_LIMIT && (w_cnt[PERF_CYC] == LIMIT_M1);

   always_comb begin
      w_nextState = r_state;
      if (clear_i) begin
         w_nextState = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (enable_i) w_nextState = RUN;
            RUN:     if (w_limitHit) w_nextState = HALTED;
            HALTED:  w_nextState = HALTED;
            default: w_nextState = IDLE;
         endcase
      end
   end

   always_comb begin
      running_o = (r_state == RUN);
      halt_o    = (r_state == HALTED);
   end

   // Events are gated by the registered RUN state so X inputs elsewhere cannot leak in.
   assign w_run = (r_state == RUN);

   always_comb begin
      w_inc             = '0;
      w_inc[PERF_CYC]   = w_run;
      w_inc[PERF_STALL] = w_run & stall_i & ~jump_i & ~branch_i;
      w_inc[PERF_FLUSH] = w_run & flush_i;
      w_inc[PERF_RET]   = w_run & retire_i;
   end

   for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
      perf_sat_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk_i   (clk_i),
         .start_i (start_i),
         .inc_i   (w_inc[g]),
         .clr_i   (clear_i),
         .count_o (w_cnt[g]),
         .sat_o   (w_sat[g])
      );
   end

   assign sat_o = |w_sat;

   always_ff @(posedge clk_i) begin
      if (!start_i) begin
         rd_data_o <= '0;
      end else begin
         rd_data_o <= w_cnt[rd_addr_i];
      end
   end

endmodule

// File: tb/tb_pipeline_perf_monitor.sv
// Bench for pipeline_perf_monitor: a 32-bit/limit-10 instance and a
// 4-bit/no-limit instance share stimulus and are checked against a model.
module tb_pipeline_perf_monitor;

   logic        clk;
   logic        start, enable, clear, stall, jump, branch, flush, retire;
   logic [1:0]  rdAddr;
   logic [31:0] rdMain;
   logic        runMain, haltMain, satMain;
   logic [3:0]  rdSmall;
   logic        runSmall, haltSmall, satSmall;

   int checks = 0;
   int errors = 0;
   bit checkEn = 0;

   // Model state per instance: index 0 = main, 1 = small.
   longint mCnt [2][4];
   longint mRd  [2];
   bit     mRun [2];
   bit     mHalt[2];
   bit     mSat [2];
   longint mMax [2] = '{64'hFFFF_FFFF, 64'd15};
   longint mLim [2] = '{10, 0};

   pipeline_perf_monitor #(.CNT_W(32), .CYCLE_LIMIT(10)) dutMain (
      .clk_i(clk), .start_i(start), .enable_i(enable), .clear_i(clear),
      .stall_i(stall), .jump_i(jump), .branch_i(branch), .flush_i(flush),
      .retire_i(retire), .rd_addr_i(rdAddr), .rd_data_o(rdMain),
      .running_o(runMain), .halt_o(haltMain), .sat_o(satMain)
   );

   pipeline_perf_monitor #(.CNT_W(4), .CYCLE_LIMIT(0)) dutSmall (
      .clk_i(clk), .start_i(start), .enable_i(enable), .clear_i(clear),
      .stall_i(stall), .jump_i(jump), .branch_i(branch), .flush_i(flush),
      .retire_i(retire), .rd_addr_i(rdAddr), .rd_data_o(rdSmall),
      .running_o(runSmall), .halt_o(haltSmall), .sat_o(satSmall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Applies one cycle of inputs, then advances the model by one clock edge.
   task automatic applyStimulus(input logic s, input logic e, input logic c,
                                input logic st, input logic j, input logic b,
                                input logic f, input logic r, input logic [1:0] a);
      bit [3:0] ev;
      longint   rdNext;
      start = s; enable = e; clear = c; stall = st; jump = j;
      branch = b; flush = f; retire = r; rdAddr = a;
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (!s) begin
            for (int k = 0; k < 4; k++) mCnt[d][k] = 0;
            mRd[d] = 0; mRun[d] = 0; mHalt[d] = 0; mSat[d] = 0;
         end else begin
            rdNext = mCnt[d][int'(a)];
            if (c) begin
               for (int k = 0; k < 4; k++) mCnt[d][k] = 0;
               mRun[d] = 0; mHalt[d] = 0; mSat[d] = 0;
            end else if (mRun[d]) begin
               ev = {r, f, st && !j && !b, 1'b1};
               for (int k = 0; k < 4; k++) begin
                  if (ev[k]) begin
                     if (mCnt[d][k] == mMax[d]) mSat[d] = 1;
                     else mCnt[d][k]++;
                  end
               end
               if (mLim[d] != 0 && mCnt[d][0] == mLim[d]) begin
                  mRun[d] = 0; mHalt[d] = 1;
               end
            end else if (!mHalt[d] && e) begin
               mRun[d] = 1;
            end
            mRd[d] = rdNext;
         end
      end
      #1;
   endtask

   task automatic checkOutput();
      checkVal("mainRd",   {32'b0, rdMain},   mRd[0]);
      checkVal("mainRun",  {63'b0, runMain},  {63'b0, mRun[0]});
      checkVal("mainHalt", {63'b0, haltMain}, {63'b0, mHalt[0]});
      checkVal("mainSat",  {63'b0, satMain},  {63'b0, mSat[0]});
      checkVal("smallRd",   {60'b0, rdSmall},   mRd[1]);
      checkVal("smallRun",  {63'b0, runSmall},  {63'b0, mRun[1]});
      checkVal("smallHalt", {63'b0, haltSmall}, {63'b0, mHalt[1]});
      checkVal("smallSat",  {63'b0, satSmall},  {63'b0, mSat[1]});
   endtask

   always @(negedge clk) begin
      if (checkEn) checkOutput();
   end

   initial begin
      int runEdges;

      // Reset state
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 2'd0);
      checkEn = 1;
      checkVal("rstRd",   {32'b0, rdMain}, 0);
      checkVal("rstRun",  {63'b0, runMain}, 0);
      checkVal("rstHalt", {63'b0, haltMain}, 0);
      checkVal("rstSat",  {63'b0, satMain}, 0);

      // Run length and halt at the limit
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 2'd0);
      runEdges = 0;
      for (int i = 0; i < 12; i++) begin
         if (runMain === 1'b1) runEdges++;
         applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 2'd0);
      end
      checkVal("t1RunEdges", runEdges, 10);
      checkVal("t1Halt", {63'b0, haltMain}, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 2'd0);
      checkVal("t1Cycle", {32'b0, rdMain}, 10);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 2'd1);
      checkVal("t1Stall", {32'b0, rdMain}, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 2'd3);
      checkVal("t1Retire", {32'b0, rdMain}, 0);

      // Control-hazard cycles are not stalls
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 2'd0);
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 2'd0);
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 2'd1);
      applyStimulus(1, 0, 0, 1, 0, 1, 0, 0, 2'd1);
      applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 2'd1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 2'd1);
      checkVal("t2Stall", {32'b0, rdMain}, 2);

      // Independent flush/retire counting and read latency
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 2'd0);
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 2'd0);
      for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 2'd0);
      for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 2'd0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 2'd3);
      checkVal("t3Retire", {32'b0, rdMain}, 6);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 2'd2);
      checkVal("t3Flush", {32'b0, rdMain}, 4);

      // Saturation on the narrow instance, limit-less run
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 2'd0);
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 2'd3);
      for (int i = 0; i < 20; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 2'd3);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 2'd3);
      checkVal("t4SmallRetire", {60'b0, rdSmall}, 15);
      checkVal("t4SmallSat",  {63'b0, satSmall}, 1);
      checkVal("t4SmallHalt", {63'b0, haltSmall}, 0);
      checkVal("t4MainRetire", {32'b0, rdMain}, 10);

      // Unknown event inputs while idle
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 2'd0);
      applyStimulus(1, 0, 0, 1'bx, 1'bx, 1'bx, 1'bx, 1'bx, 2'd3);
      applyStimulus(1, 0, 0, 1'bx, 1'bx, 1'bx, 1'bx, 1'bx, 2'd3);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 2'd3);
      checkVal("xRetire", {32'b0, rdMain}, 0);

      // Clear wins over a coincident stall
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 2'd1);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 1, 0, 0, 0, 0, 2'd1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 2'd1);
      checkVal("t5StallBefore", {32'b0, rdMain}, 5);
      applyStimulus(1, 0, 1, 1, 0, 0, 0, 0, 2'd1);
      checkVal("t5Run",  {63'b0, runMain}, 0);
      checkVal("t5Halt", {63'b0, haltMain}, 0);
      checkVal("t5Sat",  {63'b0, satSmall}, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 2'd1);
      checkVal("t5StallAfter", {32'b0, rdMain}, 0);

      // Mid-run reset, then restart only on enable
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 2'd0);
      for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 2'd0);
      checkVal("t6CycleBefore", {32'b0, rdMain}, 6);
      applyStimulus(0, 1, 0, 1, 0, 0, 1, 1, 2'd0);
      checkVal("t6Rd",  {32'b0, rdMain}, 0);
      checkVal("t6Run", {63'b0, runMain}, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 2'd0);
      checkVal("t6Idle",  {63'b0, runMain}, 0);
      checkVal("t6Cycle", {32'b0, rdMain}, 0);
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 2'd0);
      checkVal("t6Restart", {63'b0, runMain}, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 2'd0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 2'd0);
      checkVal("t6CycleAfter", {32'b0, rdMain}, 1);

      @(negedge clk);
      checkEn = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
